// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// counter sizing.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Bit-counter width; never below one bit so the counter always exists.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle of the bit-serial adder controller.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out
    );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Single full-adder cell; the only arithmetic in the serial adder datapath.
module serial_add_ctrl_fa (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell evaluated once per clock,
// LSB first, with start/busy/done handshake and registered result.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    serial_add_ctrl_if.slave bus
);

    localparam int unsigned CntW = cnt_w(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CntW-1:0]  cnt_inc;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             fa_s, fa_co;
    logic             inc_c;

    serial_add_ctrl_fa u_fa (
        .x     (a_sh_q[0]),
        .y     (b_sh_q[0]),
        .c_in  (carry_q),
        .s     (fa_s),
        .c_out (fa_co)
    );

    // Ripple incrementer built from XOR/AND so the full adder stays the sole adder.
    always_comb begin
        cnt_inc = '0;
        inc_c   = 1'b1;
        for (int i = 0; i < int'(CntW); i++) begin
            cnt_inc[i] = cnt_q[i] ^ inc_c;
            inc_c      = inc_c & cnt_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.c_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                carry_d = fa_co;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                // The newest sum bit enters at the top; the final bit completes the word.
                acc_d   = (WIDTH-1)'({fa_s, acc_q} >> 1);
                cnt_d   = cnt_inc;
                if (cnt_q == CntLast) begin
                    sum_d   = {fa_s, acc_q};
                    c_out_d = fa_co;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

    assign bus.busy  = (state_q == StRun);
    assign bus.done  = (state_q == StDone);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 (directed + random) and WIDTH=13 (random).
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8))  bus8  ();
    serial_add_ctrl_if #(.WIDTH(13)) bus13 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    serial_add_ctrl #(.WIDTH(13)) dut13 (
        .clk (clk),
        .rst (rst),
        .bus (bus13.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [8:0]  q8[$];
    logic [13:0] q13[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop the expected result whenever a DUT pulses done.
    always @(negedge clk) begin
        if (!rst && bus8.done) begin
            chk("busy_with_done8", {31'd0, bus8.busy}, 32'd0);
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done8: got sum %0h with no pending op", bus8.sum);
            end else begin
                chk("result8", {23'd0, bus8.c_out, bus8.sum}, {23'd0, q8.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus13.done) begin
            chk("busy_with_done13", {31'd0, bus13.busy}, 32'd0);
            if (q13.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done13: got sum %0h with no pending op", bus13.sum);
            end else begin
                chk("result13", {18'd0, bus13.c_out, bus13.sum}, {18'd0, q13.pop_front()});
            end
        end
    end

    task automatic wait_done8(output int n);
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (bus8.done) break;
        end
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                           input logic [8:0] exp);
        int lat;
        int busy_n;
        logic [7:0] prev;
        q8.push_back(exp);
        bus8.a = a; bus8.b = b; bus8.c_in = ci; bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        busy_n = int'(bus8.busy);
        prev = bus8.sum;
        lat = 0;
        while (lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus8.done) break;
            busy_n += int'(bus8.busy);
            chk("sum_held8", {24'd0, bus8.sum}, {24'd0, prev});
        end
        chk("latency8", lat, 8);
        chk("busy_cycles8", busy_n, 8);
    endtask

    task automatic run_op13(input logic [12:0] a, input logic [12:0] b, input logic ci);
        int lat;
        q13.push_back({1'b0, a} + {1'b0, b} + {13'd0, ci});
        bus13.a = a; bus13.b = b; bus13.c_in = ci; bus13.start = 1'b1;
        @(posedge clk);
        #1;
        bus13.start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus13.done) break;
        end
        chk("latency13", lat, 13);
    endtask

    initial begin
        int n;
        logic [7:0]  ra, rb;
        logic [12:0] sa, sb;
        logic        rc;

        bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.c_in = 1'b0;
        bus13.start = 1'b0; bus13.a = '0; bus13.b = '0; bus13.c_in = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, bus8.busy}, 32'd0);
        chk("rst_done", {31'd0, bus8.done}, 32'd0);
        chk("rst_sum", {24'd0, bus8.sum}, 32'd0);
        chk("rst_cout", {31'd0, bus8.c_out}, 32'd0);
        chk("rst_busy13", {31'd0, bus13.busy}, 32'd0);

        run_op8(8'hFF, 8'h01, 1'b0, 9'h100);
        run_op8(8'h5A, 8'h33, 1'b1, 9'h08E);

        // Start pulsed mid-run must be ignored.
        q8.push_back(9'h046);
        bus8.a = 8'h12; bus8.b = 8'h34; bus8.c_in = 1'b0; bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus8.a = 8'h01; bus8.b = 8'h01; bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        wait_done8(n);
        chk("mid_run_done_seen", {31'd0, bus8.done}, 32'd1);
        repeat (12) begin
            @(negedge clk);
            chk("mid_run_idle", {31'd0, bus8.busy}, 32'd0);
        end

        // Start held through DONE: back-to-back; operand changes during RUN have no effect.
        q8.push_back(9'h044);
        q8.push_back(9'h0FF);
        bus8.a = 8'h33; bus8.b = 8'h11; bus8.c_in = 1'b0; bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.a = 8'h0F; bus8.b = 8'hF0;
        wait_done8(n);
        chk("b2b_first_done", {31'd0, bus8.done}, 32'd1);
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        @(negedge clk);
        chk("b2b_no_idle", {31'd0, bus8.busy}, 32'd1);
        wait_done8(n);
        chk("b2b_second_done", {31'd0, bus8.done}, 32'd1);
        chk("b2b_second_lat", n, 8);

        // Reset at bit 4 aborts; start high with rst is dropped.
        bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.c_in = 1'b1; bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus8.start = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, bus8.busy}, 32'd0);
        chk("abort_sum", {24'd0, bus8.sum}, 32'd0);
        chk("abort_cout", {31'd0, bus8.c_out}, 32'd0);
        repeat (15) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, bus8.done}, 32'd0);
        end
        run_op8(8'h80, 8'h80, 1'b0, 9'h100);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            run_op8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc});
        end
        for (int i = 0; i < 1000; i++) begin
            sa = 13'($urandom);
            sb = 13'($urandom);
            rc = 1'($urandom);
            run_op13(sa, sb, rc);
        end

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q13_drained", q13.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
